tcdm_ecc_scrubber: RTL
======================

# tcdm_ecc_scrubber

Background ECC scrubber and request multiplexer between one L2 TCDM slave port and its ECC-protected SRAM bank. One instance per interleaved or private L2 bank. Forwards TCDM traffic with strict priority. In idle bank cycles it reads every word in turn, and writes back the corrected word when the bank reports a correctable error. Single-bit upsets are removed before they can accumulate into uncorrectable errors.

## Interface
- BankSize, 32768, bank depth in 32-bit words; AW = $clog2(BankSize)
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- scrub_en_i  in  1  enables scrubbing; TCDM forwarding is unaffected
- scrub_interval_i  in  16  idle cycles between consecutive scrub words
- tcdm_req_i / tcdm_wen_i  in  1 / 1  TCDM request; wen=1 read, wen=0 write
- tcdm_add_i  in  32  byte address, bank offset already removed
- tcdm_wdata_i / tcdm_be_i  in  32 / 4  write data, byte enables
- tcdm_gnt_o  out  1  grant
- tcdm_rvalid_o  out  1  response valid
- tcdm_rdata_o  out  32  read data
- tcdm_err_o  out  2  ECC status of the TCDM read, valid with tcdm_rvalid_o
- bank_req_o / bank_wen_o  out  1 / 1  bank request, same wen encoding as TCDM
- bank_add_o  out  AW  word address
- bank_wdata_o / bank_be_o  out  32 / 4  bank write data, byte enables
- bank_gnt_i  in  1  bank grant; may be low during internal read-modify-write
- bank_rdata_i / bank_err_i  in  32 / 2  read data and ECC status, one cycle after a granted read; err[0] correctable (data already corrected), err[1] uncorrectable
- scrub_fix_o / scrub_uncorr_o / pass_done_o  out  1 each  single-cycle event pulses

## Operation
- **Mux**
  - tcdm_req_i=1 selects TCDM unconditionally.
  - bank_* = TCDM fields; bank_add_o = tcdm_add_i[AW+1:2].
  - tcdm_gnt_o = tcdm_req_i & bank_gnt_i.
  - Otherwise the scrubber may drive the bank.
- **TCDM read response**
  - tcdm_rvalid_o = registered (tcdm_req_i & bank_gnt_i).
  - tcdm_rdata_o = bank_rdata_i; tcdm_err_o = bank_err_i when rvalid, else 0.
  - Writes also produce rvalid.
  - Scrub reads never assert tcdm_rvalid_o.
- **FSM**
  - IDLE: interval counter increments. When scrub_en_i=1 and count ≥ scrub_interval_i: clear counter, go READ.
  - READ: bank_req_o=1, wen=1, add=scrub_addr, be=4'hF, only while tcdm_req_i=0. A TCDM request withdraws the scrub request; retried in a later cycle. Granted → WAIT.
  - WAIT: sample bank_rdata_i/bank_err_i into fix_data.
    - err[1]=1 → pulse scrub_uncorr_o, go ADV.
    - err[0]=1 → go WB.
    - Else → ADV.
  - WB: bank_req_o=1, wen=0, be=4'hF, wdata=fix_data, only while tcdm_req_i=0. Granted → pulse scrub_fix_o, go ADV.
  - ADV: scrub_addr += 1; at BankSize-1, wrap to 0 and pulse pass_done_o. Go IDLE.
- **Hazard**
  - A granted TCDM write whose word address equals scrub_addr, seen in WAIT or WB, sets a cancel flag.
  - WB with cancel set goes to ADV without writing and without pulsing scrub_fix_o.
  - The cancel flag clears in ADV.
- **Disable**
  - scrub_en_i=0 outside IDLE: the current word finishes (including WB), then the FSM stays in IDLE.
  - scrub_addr is kept, so the pass resumes where it stopped.
- **Starvation**
  - A continuously active TCDM stalls scrubbing indefinitely; this is accepted.

## Timing
- Reset values:
  - State IDLE, scrub_addr 0, interval counter 0, cancel flag 0.
  - tcdm_rvalid_o, tcdm_err_o, all pulses, bank_req_o: 0.
  - Mux outputs follow the tcdm_* inputs combinationally.
- Reset mid-operation drops any pending write-back; no bank write follows the reset cycle.
- TCDM path adds zero cycles on request/grant and one cycle to response, the bank latency.
- Uncontended clean scrub word takes interval+1 (IDLE) + 1 READ + 1 WAIT + 1 ADV cycles.
- A correctable word adds ≥1 WB cycle.
- Full pass without errors, interval 0, no TCDM traffic: exactly 4·BankSize cycles. pass_done_o pulses in ADV of word BankSize-1.
- scrub_fix_o pulses in the WB cycle that is granted.
- scrub_uncorr_o pulses in the WAIT cycle.

## Structure
- Package tcdm_ecc_scrubber_pkg:
  - scrub_state_e {IDLE, READ, WAIT, WB, ADV}
  - localparams ERR_CORR=0, ERR_UNCORR=1
- Single module, no sub-module.
- Instanced between the TCDM slave port and the ECC SRAM wrapper.
- scrub_fix_o and scrub_uncorr_o feed the ECC manager counter increments.

## Test plan
- **Reset:** rst_i=1 for 2 cycles, TCDM read to 0x10 → bank_add_o=4, tcdm_rvalid_o=1 one cycle after grant, no scrub requests during reset.
- **Clean pass:** BankSize=16, interval=0, no traffic → 16 scrub reads at addresses 0..15, no writes, pass_done_o once at cycle 64, scrub_addr back to 0.
- **Correctable:** bank_err_i=2'b01 with rdata=0xDEADBEEF at word 5 → write to word 5, be=4'hF, wdata=0xDEADBEEF, one scrub_fix_o pulse.
- **Uncorrectable:** err=2'b10 at word 7 → scrub_uncorr_o once, no bank write, scrubbing continues at word 8.
- **Hazard:** correctable at word 3, TCDM write 0x0000_00AA to byte address 0xC during WAIT → no write-back, scrub_fix_o stays 0, the TCDM write reaches the bank.
- **Contention:** tcdm_req_i held high for 50 cycles during READ → bank always driven by TCDM, tcdm_gnt_o=bank_gnt_i. Scrub read issues on the first cycle tcdm_req_i=0.

Source files
------------

// File: rtl/tcdm_ecc_scrubber_pkg.sv
// Shared types and constants for the TCDM ECC scrubber.
//   scrub_state_e : scrub FSM states (idle wait, read, read response, write-back, advance)
//   ERR_CORR      : bit of the bank ECC status flagging a corrected single-bit error
//   ERR_UNCORR    : bit of the bank ECC status flagging an uncorrectable error
package tcdm_ecc_scrubber_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WB,
    ADV
  } scrub_state_e;

  localparam int unsigned ERR_CORR   = 0;
  localparam int unsigned ERR_UNCORR = 1;

endpackage

// File: rtl/tcdm_ecc_scrubber.sv
// Background ECC scrubber and request multiplexer in front of one ECC-protected L2 bank.
// TCDM requests always own the bank. In idle bank cycles the scrubber reads every word in
// turn and writes back the (already corrected) data when the bank reports a correctable
// error, so single-bit upsets are removed before they accumulate.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   scrub_en_i                   enable background scrubbing
//   scrub_interval_i             idle cycles between consecutive scrub words
//   tcdm_req_i/wen_i/add_i/wdata_i/be_i   TCDM slave request (wen=1 read, byte address)
//   tcdm_gnt_o/rvalid_o/rdata_o/err_o     TCDM grant and response (err valid with rvalid)
//   bank_req_o/wen_o/add_o/wdata_o/be_o   bank request (word address)
//   bank_gnt_i/rdata_i/err_i              bank grant and response, one cycle after grant
//   scrub_fix_o, scrub_uncorr_o, pass_done_o   single-cycle event pulses
module tcdm_ecc_scrubber
  import tcdm_ecc_scrubber_pkg::*;
#(
  parameter int unsigned BankSize = 32768,
  localparam int unsigned AW = $clog2(BankSize)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          scrub_en_i,
  input  logic [15:0]   scrub_interval_i,
  input  logic          tcdm_req_i,
  input  logic          tcdm_wen_i,
  input  logic [31:0]   tcdm_add_i,
  input  logic [31:0]   tcdm_wdata_i,
  input  logic [3:0]    tcdm_be_i,
  output logic          tcdm_gnt_o,
  output logic          tcdm_rvalid_o,
  output logic [31:0]   tcdm_rdata_o,
  output logic [1:0]    tcdm_err_o,
  output logic          bank_req_o,
  output logic          bank_wen_o,
  output logic [AW-1:0] bank_add_o,
  output logic [31:0]   bank_wdata_o,
  output logic [3:0]    bank_be_o,
  input  logic          bank_gnt_i,
  input  logic [31:0]   bank_rdata_i,
  input  logic [1:0]    bank_err_i,
  output logic          scrub_fix_o,
  output logic          scrub_uncorr_o,
  output logic          pass_done_o
);

  localparam logic [AW-1:0] LastAddr = AW'(BankSize - 1);

  scrub_state_e  r_state, w_state_nxt;
  logic [AW-1:0] r_scrub_addr, w_scrub_addr_nxt;
  logic [15:0]   r_interval_cnt, w_interval_cnt_nxt;
  logic          r_cancel, w_cancel_nxt;
  logic [31:0]   r_fix_data, w_fix_data_nxt;
  logic          r_rvalid;

  logic          w_scrub_req;
  logic          w_scrub_wen;
  logic          w_fix;
  logic          w_uncorr;
  logic          w_pass_done;
  logic [AW-1:0] w_tcdm_word;
  logic          w_tcdm_wr_hit;
  logic          w_unused_add;

  assign w_tcdm_word  = tcdm_add_i[AW+1:2];
  // Byte offset and bits above the bank are not needed for addressing.
  assign w_unused_add = ^{tcdm_add_i[31:AW+2], tcdm_add_i[1:0]};

  // A TCDM write to the word being scrubbed makes the held fix data stale.
  assign w_tcdm_wr_hit = tcdm_req_i & bank_gnt_i & ~tcdm_wen_i & (w_tcdm_word == r_scrub_addr);

  always_comb begin
    w_state_nxt        = r_state;
    w_scrub_addr_nxt   = r_scrub_addr;
    w_interval_cnt_nxt = r_interval_cnt;
    w_cancel_nxt       = r_cancel;
    w_fix_data_nxt     = r_fix_data;
    w_scrub_req        = 1'b0;
    w_scrub_wen        = 1'b1;
    w_fix              = 1'b0;
    w_uncorr           = 1'b0;
    w_pass_done        = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (scrub_en_i && (r_interval_cnt >= scrub_interval_i)) begin
          w_interval_cnt_nxt = '0;
          w_state_nxt        = READ;
        end else if (r_interval_cnt != 16'hFFFF) begin
          // Saturate so a long disabled period cannot wrap the count back below the interval.
          w_interval_cnt_nxt = r_interval_cnt + 16'd1;
        end
      end
      READ: begin
        // Withdrawn whenever TCDM wants the bank; retried on a later cycle.
        w_scrub_req = ~tcdm_req_i;
        if (w_scrub_req && bank_gnt_i) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        w_fix_data_nxt = bank_rdata_i;
        if (w_tcdm_wr_hit) begin
          w_cancel_nxt = 1'b1;
        end
        if (bank_err_i[ERR_UNCORR]) begin
          w_uncorr    = 1'b1;
          w_state_nxt = ADV;
        end else if (bank_err_i[ERR_CORR]) begin
          w_state_nxt = WB;
        end else begin
          w_state_nxt = ADV;
        end
      end
      WB: begin
        if (w_tcdm_wr_hit) begin
          w_cancel_nxt = 1'b1;
        end
        if (r_cancel) begin
          w_state_nxt = ADV;
        end else begin
          w_scrub_req = ~tcdm_req_i;
          w_scrub_wen = 1'b0;
          if (w_scrub_req && bank_gnt_i) begin
            w_fix       = 1'b1;
            w_state_nxt = ADV;
          end
        end
      end
      ADV: begin
        w_cancel_nxt = 1'b0;
        if (r_scrub_addr == LastAddr) begin
          w_scrub_addr_nxt = '0;
          w_pass_done      = 1'b1;
        end else begin
          w_scrub_addr_nxt = r_scrub_addr + AW'(1);
        end
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= IDLE;
      r_scrub_addr   <= '0;
      r_interval_cnt <= '0;
      r_cancel       <= 1'b0;
      r_fix_data     <= '0;
      r_rvalid       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_scrub_addr   <= w_scrub_addr_nxt;
      r_interval_cnt <= w_interval_cnt_nxt;
      r_cancel       <= w_cancel_nxt;
      r_fix_data     <= w_fix_data_nxt;
      r_rvalid       <= tcdm_req_i & bank_gnt_i;
    end
  end

  // Bank mux: TCDM has strict priority; scrub requests are masked during reset so a
  // pending write-back cannot reach the bank in the reset cycle.
  always_comb begin
    bank_req_o   = tcdm_req_i;
    bank_wen_o   = tcdm_wen_i;
    bank_add_o   = w_tcdm_word;
    bank_wdata_o = tcdm_wdata_i;
    bank_be_o    = tcdm_be_i;
    if (!tcdm_req_i && w_scrub_req && !rst_i) begin
      bank_req_o   = 1'b1;
      bank_wen_o   = w_scrub_wen;
      bank_add_o   = r_scrub_addr;
      bank_wdata_o = r_fix_data;
      bank_be_o    = 4'hF;
    end
  end

  assign tcdm_gnt_o     = tcdm_req_i & bank_gnt_i;
  assign tcdm_rvalid_o  = r_rvalid;
  assign tcdm_rdata_o   = bank_rdata_i;
  assign tcdm_err_o     = r_rvalid ? bank_err_i : 2'b00;

  assign scrub_fix_o    = w_fix & ~rst_i;
  assign scrub_uncorr_o = w_uncorr & ~rst_i;
  assign pass_done_o    = w_pass_done & ~rst_i;

endmodule
